// File: rtl/tri_stream_buffer.sv
// tri_stream_buffer
//   Receiving end of the get_vertices triangle interface. A frame starts with a
//   start request, which launches get_vertices with a single go pulse. Every
//   triangle beat that arrives while collecting is captured in a
//   first-word-fall-through FIFO. get_vertices cannot be stalled, so the FIFO
//   absorbs its bursts. The FIFO replays triangles to the transform stage over a
//   valid/ready handshake. Once the object is complete and the FIFO has drained,
//   the block pulses frame_done.
//
// Ports
//   clk_in          clock
//   rst_in          synchronous reset, active high
//   start_in        frame start request (honoured only when idle)
//   go_out          one-cycle launch pulse to get_vertices
//   tri_in          incoming triangle: [0..2] vertex xyz, [3] attribute triple
//   tri_valid_in    tri_in carries a triangle this cycle
//   obj_done_in     last triangle of the object has been sent
//   tri_out         FIFO head triangle (zero while empty)
//   tri_valid_out   FIFO not empty
//   tri_ready_in    downstream accepts tri_out
//   frame_done_out  one-cycle pulse: object fully consumed
//   busy_out        frame in progress
//   overflow_out    sticky: a triangle was dropped on a full FIFO
//   tri_count_out   triangles accepted this frame (saturating)
module tri_stream_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  output logic                         go_out,
  input  logic [3:0][2:0][WIDTH-1:0]   tri_in,
  input  logic                         tri_valid_in,
  input  logic                         obj_done_in,
  output logic [3:0][2:0][WIDTH-1:0]   tri_out,
  output logic                         tri_valid_out,
  input  logic                         tri_ready_in,
  output logic                         frame_done_out,
  output logic                         busy_out,
  output logic                         overflow_out,
  output logic [CNT_W-1:0]             tri_count_out
);

  localparam int TRI_W = 12 * WIDTH;
  localparam int AW    = $clog2(DEPTH);
  // One extra bit so that full (DEPTH) and empty (0) are distinct fill values.
  localparam int FW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TRI_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]      fill_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   count_q;
  logic               frame_done_q;

  logic empty, full, push_req, push, pop, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign empty    = (fill_q == '0);
  assign full     = (fill_q == FW'(DEPTH));
  assign pop      = !empty && tri_ready_in;
  assign push_req = (state_q == COLLECT) && tri_valid_in;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    state_d = state_q;
    go_out  = 1'b0;
    case (state_q)
      IDLE:    if (start_in) state_d = LAUNCH;
      LAUNCH: begin
        go_out  = 1'b1;
        state_d = COLLECT;
      end
      COLLECT: if (obj_done_in) state_d = DRAIN;
      DRAIN:   if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, pointers, fill level, status.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Registered so the pulse lands in the first IDLE cycle.
      frame_done_q <= (state_q == DRAIN) && empty;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fill_q <= fill_q + 1'b1;
      else if (pop && !push) fill_q <= fill_q - 1'b1;
      if ((state_q == IDLE) && start_in) begin
        overflow_q <= 1'b0;
        count_q    <= '0;
      end else begin
        if (drop) overflow_q <= 1'b1;
        if (push) count_q    <= sat_inc(count_q);
      end
    end
  end

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= tri_in;
  end

  assign tri_out        = empty ? '0 : mem_q[rd_ptr_q];
  assign tri_valid_out  = !empty;
  assign frame_done_out = frame_done_q;
  assign busy_out       = (state_q != IDLE);
  assign overflow_out   = overflow_q;
  assign tri_count_out  = count_q;

endmodule

// File: tb/tb_tri_stream_buffer.sv
module tb_tri_stream_buffer;

  localparam int W     = 32;
  localparam int TW    = 12 * W;
  localparam int CNT_W = 16;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b1;
  logic                     start_in = 1'b0;
  logic                     go_out;
  logic [3:0][2:0][W-1:0]   tri_in = '0;
  logic                     tri_valid_in = 1'b0;
  logic                     obj_done_in = 1'b0;
  logic [3:0][2:0][W-1:0]   tri_out;
  logic                     tri_valid_out;
  logic                     tri_ready_in = 1'b0;
  logic                     frame_done_out;
  logic                     busy_out;
  logic                     overflow_out;
  logic [CNT_W-1:0]         tri_count_out;

  tri_stream_buffer #(.WIDTH(W), .DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .go_out        (go_out),
    .tri_in        (tri_in),
    .tri_valid_in  (tri_valid_in),
    .obj_done_in   (obj_done_in),
    .tri_out       (tri_out),
    .tri_valid_out (tri_valid_out),
    .tri_ready_in  (tri_ready_in),
    .frame_done_out(frame_done_out),
    .busy_out      (busy_out),
    .overflow_out  (overflow_out),
    .tri_count_out (tri_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_pass  = 0;
  int go_cnt  = 0;
  int fd_cnt  = 0;
  logic [TW-1:0] exp_q [$];

  function automatic logic [TW-1:0] make_tri(input int tag);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < 12; k++)
      t[k*W +: W] = {8'(tag), 8'(k), 16'(tag * 31 + k * 7) ^ 16'hBEEF};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pulse counters and scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (go_out) go_cnt++;
    if (frame_done_out) fd_cnt++;
  end

  always @(negedge clk_in) begin
    logic [TW-1:0] got, exp;
    if (!rst_in && tri_valid_out && tri_ready_in) begin
      got = tri_out;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL tri_out unexpected: got tag %0h expected none", got[31:24]);
      end else begin
        exp = exp_q.pop_front();
        if (got === exp) n_pass++;
        else $display("FAIL tri_out: got %0h expected %0h", got, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int tag, input bit done, input bit expect_it);
    tri_valid_in = 1'b1;
    tri_in       = make_tri(tag);
    obj_done_in  = done;
    if (expect_it) exp_q.push_back(make_tri(tag));
    tick();
    tri_valid_in = 1'b0;
    obj_done_in  = 1'b0;
  endtask

  task automatic start_frame();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (!busy_out) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: busy_out still 1 after %0d cycles, required 0", name, budget);
    repeat (3) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int go0, fd0;
    logic [TW-1:0] t_out;

    // 1: reset state
    rst_in = 1'b1;
    repeat (2) tick();
    @(negedge clk_in);
    t_out = tri_out;
    check("rst go_out", 64'(go_out), 64'd0);
    check("rst tri_valid_out", 64'(tri_valid_out), 64'd0);
    check("rst frame_done_out", 64'(frame_done_out), 64'd0);
    check("rst busy_out", 64'(busy_out), 64'd0);
    check("rst overflow_out", 64'(overflow_out), 64'd0);
    check("rst tri_count_out", 64'(tri_count_out), 64'd0);
    check("rst tri_out", t_out[63:0], 64'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // 2: basic frame of three triangles
    tri_ready_in = 1'b1;
    go0 = go_cnt; fd0 = fd_cnt;
    start_frame();
    check("t2 busy", 64'(busy_out), 64'd1);
    send(11, 1'b0, 1'b1);
    send(12, 1'b0, 1'b1);
    send(13, 1'b1, 1'b1);
    wait_idle("t2 idle", 20);
    check("t2 go pulses", 64'(go_cnt - go0), 64'd1);
    check("t2 frame_done pulses", 64'(fd_cnt - fd0), 64'd1);
    check("t2 tri_count", 64'(tri_count_out), 64'd3);
    check("t2 scoreboard empty", 64'(exp_q.size()), 64'd0);

    // 3: overflow on a full FIFO
    tri_ready_in = 1'b0;
    go0 = go_cnt; fd0 = fd_cnt;
    start_frame();
    for (int t = 1; t <= 8; t++) send(t, 1'b0, 1'b1);
    @(negedge clk_in);
    check("t3 valid after 8", 64'(tri_valid_out), 64'd1);
    check("t3 overflow before 9", 64'(overflow_out), 64'd0);
    check("t3 count after 8", 64'(tri_count_out), 64'd8);
    tick();
    send(9, 1'b0, 1'b0);
    @(negedge clk_in);
    check("t3 overflow", 64'(overflow_out), 64'd1);
    check("t3 count after 9", 64'(tri_count_out), 64'd8);
    tick();
    tri_ready_in = 1'b1;
    repeat (12) tick();
    @(negedge clk_in);
    check("t3 drained valid", 64'(tri_valid_out), 64'd0);
    check("t3 scoreboard empty", 64'(exp_q.size()), 64'd0);
    tick();
    send(99, 1'b1, 1'b1);
    wait_idle("t3 idle", 20);
    check("t3 frame_done pulses", 64'(fd_cnt - fd0), 64'd1);
    check("t3 overflow sticky", 64'(overflow_out), 64'd1);

    // 4: push and pop on a full FIFO; pointers wrap over 20 triangles
    tri_ready_in = 1'b0;
    fd0 = fd_cnt;
    start_frame();
    check("t4 overflow cleared", 64'(overflow_out), 64'd0);
    check("t4 count cleared", 64'(tri_count_out), 64'd0);
    for (int t = 20; t <= 27; t++) send(t, 1'b0, 1'b1);
    tri_ready_in = 1'b1;
    for (int t = 28; t <= 38; t++) send(t, 1'b0, 1'b1);
    send(39, 1'b1, 1'b1);
    wait_idle("t4 idle", 30);
    check("t4 overflow", 64'(overflow_out), 64'd0);
    check("t4 count", 64'(tri_count_out), 64'd20);
    check("t4 frame_done pulses", 64'(fd_cnt - fd0), 64'd1);
    check("t4 scoreboard empty", 64'(exp_q.size()), 64'd0);

    // 5: reset mid-collect
    tri_ready_in = 1'b0;
    go0 = go_cnt; fd0 = fd_cnt;
    start_frame();
    for (int t = 50; t <= 53; t++) send(t, 1'b0, 1'b0);
    @(negedge clk_in);
    check("t5 valid before reset", 64'(tri_valid_out), 64'd1);
    tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    check("t5 no second go", 64'(go_cnt - go0), 64'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    t_out = tri_out;
    check("t5 valid after reset", 64'(tri_valid_out), 64'd0);
    check("t5 tri_out after reset", t_out[63:0], 64'd0);
    tick();
    tri_ready_in = 1'b1;
    send(60, 1'b0, 1'b0);
    send(61, 1'b1, 1'b0);
    repeat (5) tick();
    @(negedge clk_in);
    check("t5 valid after beats", 64'(tri_valid_out), 64'd0);
    check("t5 busy", 64'(busy_out), 64'd0);
    check("t5 count", 64'(tri_count_out), 64'd0);
    check("t5 no frame_done", 64'(fd_cnt - fd0), 64'd0);
    check("t5 go total", 64'(go_cnt - go0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
